// File: rtl/bt_cmd_parser.sv
// bt_cmd_parser: frames 4-byte commands (header, cmd, arg, xor checksum)
// from a UART byte stream. Ports: clk, rst, rx_data/rx_done in;
// cmd_out/arg_out/cmd_valid, frame_err/err_count out.
module bt_cmd_parser #(
    parameter logic [7:0]  HEADER         = 8'hAA,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000,
    parameter int          DATA_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_done,
    output logic [DATA_WIDTH-1:0] cmd_out,
    output logic [DATA_WIDTH-1:0] arg_out,
    output logic                  cmd_valid,
    output logic                  frame_err,
    output logic [7:0]            err_count
);

    typedef enum logic [1:0] {
        WAIT_HDR,
        GET_CMD,
        GET_ARG,
        GET_CHK
    } state_e;

    state_e                state_q, state_d;
    logic [31:0]           timer_q, timer_d;
    logic [DATA_WIDTH-1:0] cmd_sh_q, cmd_sh_d;
    logic [DATA_WIDTH-1:0] arg_sh_q, arg_sh_d;
    logic [DATA_WIDTH-1:0] cmd_out_q, cmd_out_d;
    logic [DATA_WIDTH-1:0] arg_out_q, arg_out_d;
    logic                  cmd_valid_q, cmd_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic [7:0]            err_count_q, err_count_d;

    logic                  in_frame;
    logic                  expired;
    logic                  drop;

    assign in_frame = (state_q != WAIT_HDR);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign expired  = in_frame && !rx_done &&
                      (timer_q == TIMEOUT_CYCLES - 32'd1);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        cmd_sh_d    = cmd_sh_q;
        arg_sh_d    = arg_sh_q;
        cmd_out_d   = cmd_out_q;
        arg_out_d   = arg_out_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        err_count_d = err_count_q;
        drop        = 1'b0;

        if (!in_frame || rx_done) begin
            timer_d = '0;
        end else if (expired) begin
            timer_d = '0;
            state_d = WAIT_HDR;
            drop    = 1'b1;
        end else begin
            timer_d = timer_q + 32'd1;
        end

        unique case (state_q)
            WAIT_HDR: begin
                if (rx_done && rx_data == HEADER) begin
                    state_d = GET_CMD;
                end
            end
            GET_CMD: begin
                if (rx_done) begin
                    cmd_sh_d = rx_data;
                    state_d  = GET_ARG;
                end
            end
            GET_ARG: begin
                if (rx_done) begin
                    arg_sh_d = rx_data;
                    state_d  = GET_CHK;
                end
            end
            GET_CHK: begin
                if (rx_done) begin
                    state_d = WAIT_HDR;
                    if (rx_data == (cmd_sh_q ^ arg_sh_q)) begin
                        cmd_out_d   = cmd_sh_q;
                        arg_out_d   = arg_sh_q;
                        cmd_valid_d = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            default: state_d = WAIT_HDR;
        endcase

        if (drop) begin
            frame_err_d = 1'b1;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_HDR;
            timer_q     <= '0;
            cmd_sh_q    <= '0;
            arg_sh_q    <= '0;
            cmd_out_q   <= '0;
            arg_out_q   <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cmd_sh_q    <= cmd_sh_d;
            arg_sh_q    <= arg_sh_d;
            cmd_out_q   <= cmd_out_d;
            arg_out_q   <= arg_out_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign cmd_out   = cmd_out_q;
    assign arg_out   = arg_out_q;
    assign cmd_valid = cmd_valid_q;
    assign frame_err = frame_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_bt_cmd_parser.sv
// tb_bt_cmd_parser: directed bench for bt_cmd_parser.
// Drives bytes on negedges, checks registered outputs on negedges.
module tb_bt_cmd_parser;

    localparam logic [31:0] TO = 32'd100;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] cmd_out;
    logic [7:0] arg_out;
    logic       cmd_valid;
    logic       frame_err;
    logic [7:0] err_count;

    int checks;
    int failures;

    bt_cmd_parser #(
        .HEADER(8'hAA),
        .TIMEOUT_CYCLES(TO),
        .DATA_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .cmd_out(cmd_out),
        .arg_out(arg_out),
        .cmd_valid(cmd_valid),
        .frame_err(frame_err),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; strobes one byte, returns at the next negedge.
    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        send(a);
        send(b);
        send(c);
        send(d);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        rx_done  = 1'b0;
        rx_data  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cmd", 32'(cmd_out), 32'h00);
        chk("rst_arg", 32'(arg_out), 32'h00);
        chk("rst_valid", 32'(cmd_valid), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_cnt", 32'(err_count), 32'h00);
        rst = 1'b0;
        @(negedge clk);

        // valid frame
        frame(8'hAA, 8'h12, 8'h34, 8'h26);
        chk("v1_valid", 32'(cmd_valid), 32'h1);
        chk("v1_ferr", 32'(frame_err), 32'h0);
        chk("v1_cmd", 32'(cmd_out), 32'h12);
        chk("v1_arg", 32'(arg_out), 32'h34);
        @(negedge clk);
        chk("v1_pulse", 32'(cmd_valid), 32'h0);
        chk("v1_cnt", 32'(err_count), 32'h00);

        // bad checksum
        frame(8'hAA, 8'h12, 8'h34, 8'h27);
        chk("b1_ferr", 32'(frame_err), 32'h1);
        chk("b1_valid", 32'(cmd_valid), 32'h0);
        chk("b1_cnt", 32'(err_count), 32'h01);
        chk("b1_cmd", 32'(cmd_out), 32'h12);
        chk("b1_arg", 32'(arg_out), 32'h34);
        @(negedge clk);
        chk("b1_pulse", 32'(frame_err), 32'h0);

        // leading garbage ignored
        send(8'h55);
        send(8'h00);
        chk("g_ferr", 32'(frame_err), 32'h0);
        frame(8'hAA, 8'h01, 8'h02, 8'h03);
        chk("g_valid", 32'(cmd_valid), 32'h1);
        chk("g_cmd", 32'(cmd_out), 32'h01);
        chk("g_arg", 32'(arg_out), 32'h02);
        chk("g_cnt", 32'(err_count), 32'h01);

        // header value inside a frame is data
        frame(8'hAA, 8'hAA, 8'hAA, 8'h00);
        chk("h_valid", 32'(cmd_valid), 32'h1);
        chk("h_cmd", 32'(cmd_out), 32'hAA);
        chk("h_arg", 32'(arg_out), 32'hAA);
        @(negedge clk);

        // timeout
        send(8'hAA);
        send(8'h05);
        repeat (TO - 1) @(negedge clk);
        chk("to_early", 32'(frame_err), 32'h0);
        @(negedge clk);
        chk("to_ferr", 32'(frame_err), 32'h1);
        chk("to_cnt", 32'(err_count), 32'h02);
        @(negedge clk);
        chk("to_pulse", 32'(frame_err), 32'h0);
        frame(8'hAA, 8'h07, 8'h08, 8'h0F);
        chk("to_valid", 32'(cmd_valid), 32'h1);
        chk("to_cmd", 32'(cmd_out), 32'h07);
        chk("to_arg", 32'(arg_out), 32'h08);

        // byte on the expiry cycle wins
        send(8'hAA);
        send(8'h05);
        repeat (TO - 1) @(negedge clk);
        send(8'h06);
        chk("bw_ferr", 32'(frame_err), 32'h0);
        send(8'h03);
        chk("bw_valid", 32'(cmd_valid), 32'h1);
        chk("bw_cmd", 32'(cmd_out), 32'h05);
        chk("bw_arg", 32'(arg_out), 32'h06);
        chk("bw_cnt", 32'(err_count), 32'h02);

        // reset mid-frame
        send(8'hAA);
        send(8'h12);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rm_cmd", 32'(cmd_out), 32'h00);
        chk("rm_cnt", 32'(err_count), 32'h00);
        frame(8'hAA, 8'h01, 8'h02, 8'h03);
        chk("rm_valid", 32'(cmd_valid), 32'h1);
        chk("rm_cmd2", 32'(cmd_out), 32'h01);

        // reset together with the checksum byte
        send(8'hAA);
        send(8'h01);
        send(8'h02);
        rst = 1'b1;
        send(8'h03);
        rst = 1'b0;
        chk("rc_valid", 32'(cmd_valid), 32'h0);
        chk("rc_cmd", 32'(cmd_out), 32'h00);
        @(negedge clk);
        chk("rc_valid2", 32'(cmd_valid), 32'h0);

        // saturation: 256 bad frames
        for (int i = 1; i <= 256; i++) begin
            frame(8'hAA, 8'h00, 8'h00, 8'h01);
            chk("sat_ferr", 32'(frame_err), 32'h1);
            chk("sat_cnt", 32'(err_count), (i > 255) ? 32'd255 : 32'(i));
        end
        @(negedge clk);
        chk("sat_hold", 32'(err_count), 32'hFF);
        chk("sat_cmd", 32'(cmd_out), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
